fm_mem_ctrl: RTL and testbench
==============================

# fm_mem_ctrl

Sequencer for the 144-bit × 8192-deep feature-map DRM and its DDR width converters, running entirely in `calc_clk`. It turns the layer scheduler's 3-bit `current_state` command into three things: write/read addresses, the DDR-vs-Conv write-mux select, and read-valid strobes for each phase (LOAD from DDR, CONV, STORE to DDR). It counts transfers against per-phase lengths and pulses `state_rst` back to the scheduler when a phase completes.

## Interface
- `FM_MEM_DEPTH`, 13, address width of the feature-map DRM.
- `LEN_WIDTH`, 14, width of transfer-length fields; must be > `FM_MEM_DEPTH` so a full 8192-word phase is expressible.
- `calc_clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `current_state` in 3: scheduler command. 0 = IDLE, 1 = LOAD, 2 = CONV, 3 = STORE; 4–7 are treated as IDLE.
- `cfg_wr_base` in `FM_MEM_DEPTH`: first write address, latched at phase start.
- `cfg_rd_base` in `FM_MEM_DEPTH`: first read address, latched at phase start.
- `cfg_wr_len` in `LEN_WIDTH`: words to write (LOAD, CONV), latched at phase start.
- `cfg_rd_len` in `LEN_WIDTH`: words to read (CONV, STORE), latched at phase start.
- `ddr_wr_valid` in 1: DDR in-converter word valid.
- `conv_wr_valid` in 1: conv engine result valid.
- `conv_rd_req` in 1: conv engine requests the next input word.
- `store_ready` in 1: out-converter can accept a word this cycle.
- `wr_en` out 1: gated DRM write enable.
- `wr_addr` out `FM_MEM_DEPTH`: DRM write address.
- `rd_addr` out `FM_MEM_DEPTH`: DRM read address.
- `fm_ddr_wr` out 1: write-mux select, 1 = DDR data.
- `rd_valid` out 1: DRM read data valid, 1 cycle after issue.
- `state_rst` out 1: one-cycle phase-done pulse.
- `busy` out 1: high in LOAD, CONV and STORE.

## Operation
- **FSM states:** S_IDLE, S_LOAD, S_CONV, S_STORE, S_DONE.
- **Phase start:** in S_IDLE, when `current_state` is 1, 2 or 3:
  - latch bases and lengths;
  - clear `wr_cnt`, `rd_cnt`;
  - load `wr_addr`/`rd_addr` with the bases;
  - enter the matching state.
- **Writes:**
  - A write is accepted when the source valid is high and `wr_cnt < wr_len`.
  - Source is `ddr_wr_valid` in S_LOAD and `conv_wr_valid` in S_CONV.
  - `wr_en` is combinational from the accept condition.
  - On accept, `wr_addr` and `wr_cnt` increment at the next edge.
  - Valids in any other state, or past the length, are dropped (`wr_en` = 0).
- **Reads:**
  - A read is issued when `rd_cnt < rd_len` and the request is high.
  - Request is `conv_rd_req` in S_CONV and `store_ready` in S_STORE.
  - `rd_addr` presented in the issue cycle addresses the data returned next cycle.
  - `rd_addr` and `rd_cnt` increment on issue.
- **`fm_ddr_wr`** = 1 only in S_LOAD; 0 everywhere else.
- **Addresses** wrap modulo 2^`FM_MEM_DEPTH`: base + count, carry discarded.
- **Completion:** all required counts reach their lengths and no read is in flight (`rd_valid` pipeline empty).
  - LOAD needs the write count only; STORE needs the read count only; CONV needs both.
  - Length 0 counts as satisfied immediately.
- **On completion:** go to S_DONE and assert `state_rst` for exactly that one cycle (registered, first cycle of S_DONE).
- **Leaving S_DONE:** stay until `current_state` returns to IDLE, then go to S_IDLE. A re-issued command is not re-executed without passing through IDLE.
- **Abort:** if `current_state` goes to IDLE while in LOAD, CONV or STORE:
  - go to S_IDLE next cycle, with no `state_rst`;
  - counters clear;
  - an in-flight `rd_valid` still completes.
  - A change directly to a different nonzero command mid-phase is ignored until the phase ends.

## Timing
- **Reset values:** all registers and outputs are 0 (`wr_en`, `wr_addr`, `rd_addr`, `fm_ddr_wr`, `rd_valid`, `state_rst`, `busy`), FSM in S_IDLE.
- **Start latency:** 1 cycle. The command is seen at edge N; the first write or read can be accepted in cycle N+1.
- **Throughput:** 1 write and 1 read per cycle, and both may occur in the same cycle in CONV.
- **Read latency:** `rd_valid` follows the issue cycle by exactly 1 cycle.
- **Done latency:** `state_rst` rises 1 cycle after the cycle holding the final accept (writes) or the final `rd_valid` (reads).

## Structure
- Shared package `fm_pkg`:
  - command encodings `FM_CMD_IDLE`/`LOAD`/`CONV`/`STORE`;
  - FSM state enum;
  - `FM_MEM_DEPTH` default.
- Natural sub-module: `fm_addr_counter`, instantiated twice (write side, read side).
  - It holds base load, increment-on-fire, a length-compare `done` flag, and wrap.
  - The FSM, mux select and `rd_valid` pipe stay in the top.

## Test plan
- **LOAD:** base 0x1FFE, wr_len 4, `ddr_wr_valid` on for 6 cycles.
  - `wr_addr` runs 1FFE, 1FFF, 0000, 0001 with `wr_en` on exactly 4 cycles.
  - `fm_ddr_wr` = 1 throughout.
  - `state_rst` pulses once, 1 cycle after the 4th accept.
- **STORE:** rd_len 3, `store_ready` toggling 1,0,1,1.
  - `rd_addr` base, base+1, base+2 issued only in ready cycles.
  - `rd_valid` is 3 single pulses, each 1 cycle after its issue.
  - `state_rst` 1 cycle after the last `rd_valid`.
- **CONV:** rd_len 5, wr_len 2, reads finishing before writes.
  - No `state_rst` until the 2nd `conv_wr_valid` is accepted.
  - The simultaneous read+write cycle increments both addresses.
- **Zero length:** LOAD with wr_len 0 → `state_rst` at cycle N+1, with no `wr_en`.
- **Abort:** `current_state` drops to 0 after 2 of 8 LOAD writes.
  - Back in S_IDLE with no `state_rst`.
  - A new LOAD restarts at the latched base, count 0.
- **Reset and illegal command:** assert `rst` mid-STORE, then command 5.
  - After `rst`, all outputs are 0 immediately (asynchronously).
  - Command 5 leaves the FSM idle and `busy` = 0.

Source files
------------

// File: rtl/fm_pkg.sv
// Shared encodings for the feature-map memory sequencer: scheduler commands,
// FSM states and default geometry of the 144b x 8192 DRM.
package fm_pkg;
    localparam int FM_DEPTH_DEFAULT = 13;
    localparam int LEN_WIDTH_DEFAULT = 14;

    localparam logic [2:0] FM_CMD_IDLE  = 3'd0;
    localparam logic [2:0] FM_CMD_LOAD  = 3'd1;
    localparam logic [2:0] FM_CMD_CONV  = 3'd2;
    localparam logic [2:0] FM_CMD_STORE = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CONV,
        S_STORE,
        S_DONE
    } fm_state_e;
endpackage

// File: rtl/fm_mem_ctrl_counter.sv
// Base-loaded address/transfer counter with a length limit; one instance
// per DRM port. Address wraps naturally at 2^AW.
module fm_addr_counter #(
    parameter int AW = 13,
    parameter int LW = 14
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          clear_i,
    input  logic          fire_i,
    input  logic [AW-1:0] base_i,
    input  logic [LW-1:0] len_i,
    output logic [AW-1:0] addr_o,
    output logic          avail_o,
    output logic          done_nx_o
);
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] cnt_q, cnt_d, len_q, len_d;

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        len_d  = len_q;
        if (load_i) begin
            addr_d = base_i;
            cnt_d  = '0;
            len_d  = len_i;
        end else if (clear_i) begin
            cnt_d = '0;
        end else if (fire_i) begin
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            len_q  <= len_d;
        end
    end

    assign addr_o  = addr_q;
    assign avail_o = cnt_q < len_q;
    // Look-ahead: count will have reached the length after this edge.
    assign done_nx_o = (cnt_q + LW'(fire_i)) >= len_q;
endmodule

// File: rtl/fm_mem_ctrl.sv
// Feature-map DRM sequencer: turns scheduler commands into write/read
// addresses, DDR/conv write-mux select, read-valid strobes and a done pulse.
module fm_mem_ctrl
    import fm_pkg::*;
#(
    parameter int FM_MEM_DEPTH = FM_DEPTH_DEFAULT,
    parameter int LEN_WIDTH    = LEN_WIDTH_DEFAULT
) (
    input  logic                    calc_clk,
    input  logic                    rst,
    input  logic [2:0]              current_state,
    input  logic [FM_MEM_DEPTH-1:0] cfg_wr_base,
    input  logic [FM_MEM_DEPTH-1:0] cfg_rd_base,
    input  logic [LEN_WIDTH-1:0]    cfg_wr_len,
    input  logic [LEN_WIDTH-1:0]    cfg_rd_len,
    input  logic                    ddr_wr_valid,
    input  logic                    conv_wr_valid,
    input  logic                    conv_rd_req,
    input  logic                    store_ready,
    output logic                    wr_en,
    output logic [FM_MEM_DEPTH-1:0] wr_addr,
    output logic [FM_MEM_DEPTH-1:0] rd_addr,
    output logic                    fm_ddr_wr,
    output logic                    rd_valid,
    output logic                    state_rst,
    output logic                    busy
);
    fm_state_e state_q, state_d;
    logic rd_vld_q, state_rst_q, state_rst_d;
    logic cmd_act, start_done, phase_done, ld, clr;
    logic wr_fire, rd_fire, wr_avail, rd_avail, wr_done_nx, rd_done_nx;

    // Codes 4-7 behave exactly like IDLE.
    assign cmd_act = (current_state == FM_CMD_LOAD) || (current_state == FM_CMD_CONV) ||
                     (current_state == FM_CMD_STORE);

    assign wr_fire = wr_avail && (((state_q == S_LOAD) && ddr_wr_valid) ||
                                  ((state_q == S_CONV) && conv_wr_valid));
    assign rd_fire = rd_avail && (((state_q == S_CONV) && conv_rd_req) ||
                                  ((state_q == S_STORE) && store_ready));

    always_comb begin
        start_done = 1'b0;
        case (current_state)
            FM_CMD_LOAD:  start_done = (cfg_wr_len == '0);
            FM_CMD_CONV:  start_done = (cfg_wr_len == '0) && (cfg_rd_len == '0);
            FM_CMD_STORE: start_done = (cfg_rd_len == '0);
            default:      start_done = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ld         = 1'b0;
        clr        = 1'b0;
        phase_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_act) begin
                    ld = 1'b1;
                    if (start_done)                         state_d = S_DONE;
                    else if (current_state == FM_CMD_LOAD)  state_d = S_LOAD;
                    else if (current_state == FM_CMD_CONV)  state_d = S_CONV;
                    else                                    state_d = S_STORE;
                end
            end
            S_LOAD, S_CONV, S_STORE: begin
                // Read side is finished only once no read issues this cycle,
                // so the last rd_valid has drained when DONE is entered.
                if (state_q == S_LOAD)      phase_done = wr_done_nx;
                else if (state_q == S_CONV) phase_done = wr_done_nx && rd_done_nx && !rd_fire;
                else                        phase_done = rd_done_nx && !rd_fire;
                if (!cmd_act) begin
                    state_d = S_IDLE;
                    clr     = 1'b1;
                end else if (phase_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  if (!cmd_act) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        state_rst_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    always_ff @(posedge calc_clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_vld_q    <= 1'b0;
            state_rst_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_vld_q    <= rd_fire;
            state_rst_q <= state_rst_d;
        end
    end

    fm_addr_counter #(.AW(FM_MEM_DEPTH), .LW(LEN_WIDTH)) u_wr_cnt (
        .clk_i(calc_clk), .rst_i(rst), .load_i(ld), .clear_i(clr), .fire_i(wr_fire),
        .base_i(cfg_wr_base), .len_i(cfg_wr_len),
        .addr_o(wr_addr), .avail_o(wr_avail), .done_nx_o(wr_done_nx)
    );

    fm_addr_counter #(.AW(FM_MEM_DEPTH), .LW(LEN_WIDTH)) u_rd_cnt (
        .clk_i(calc_clk), .rst_i(rst), .load_i(ld), .clear_i(clr), .fire_i(rd_fire),
        .base_i(cfg_rd_base), .len_i(cfg_rd_len),
        .addr_o(rd_addr), .avail_o(rd_avail), .done_nx_o(rd_done_nx)
    );

    assign wr_en     = wr_fire;
    assign fm_ddr_wr = (state_q == S_LOAD);
    assign rd_valid  = rd_vld_q;
    assign state_rst = state_rst_q;
    assign busy      = (state_q == S_LOAD) || (state_q == S_CONV) || (state_q == S_STORE);
endmodule

// File: tb/tb_fm_mem_ctrl.sv
// Directed and randomized phases of fm_mem_ctrl checked against a
// transaction-level model of accepts, issues and the done cycle.
module tb_fm_mem_ctrl;
    logic        calc_clk = 1'b0;
    logic        rst;
    logic [2:0]  current_state;
    logic [12:0] cfg_wr_base, cfg_rd_base;
    logic [13:0] cfg_wr_len, cfg_rd_len;
    logic        ddr_wr_valid, conv_wr_valid, conv_rd_req, store_ready;
    logic        wr_en, fm_ddr_wr, rd_valid, state_rst, busy;
    logic [12:0] wr_addr, rd_addr;

    int tests = 0;
    int fails = 0;
    bit wv[64];
    bit rq[64];

    fm_mem_ctrl dut (
        .calc_clk(calc_clk), .rst(rst), .current_state(current_state),
        .cfg_wr_base(cfg_wr_base), .cfg_rd_base(cfg_rd_base),
        .cfg_wr_len(cfg_wr_len), .cfg_rd_len(cfg_rd_len),
        .ddr_wr_valid(ddr_wr_valid), .conv_wr_valid(conv_wr_valid),
        .conv_rd_req(conv_rd_req), .store_ready(store_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr(rd_addr), .fm_ddr_wr(fm_ddr_wr),
        .rd_valid(rd_valid), .state_rst(state_rst), .busy(busy)
    );

    always #5 calc_clk = ~calc_clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive_idle_inputs();
        ddr_wr_valid = 0; conv_wr_valid = 0; conv_rd_req = 0; store_ready = 0;
    endtask

    // Runs one command for T cycles using wv[]/rq[] as per-cycle source
    // valids / read requests, then drops the command back to IDLE.
    task automatic run_phase(input logic [2:0] cmd, input int wb, input int rb,
                             input int wl, input int rl, input int T);
        bit wacc[64];
        bit iss[64];
        int waddr[64];
        int raddr[64];
        int wk = 0, rk = 0, last_w = -1, last_rv = -1, d = -1, done;
        bit need_w, need_r;
        logic [4:0] ev, av;
        need_w = (cmd == 3'd1) || (cmd == 3'd2);
        need_r = (cmd == 3'd2) || (cmd == 3'd3);
        for (int c = 0; c < T; c++) begin
            wacc[c] = need_w && wv[c] && (wk < wl);
            if (wacc[c]) begin
                waddr[c] = (wb + wk) % 8192;
                wk++;
                if (wk == wl) last_w = c;
            end
            iss[c] = need_r && rq[c] && (rk < rl);
            if (iss[c]) begin
                raddr[c] = (rb + rk) % 8192;
                rk++;
                if (rk == rl) last_rv = c + 1;
            end
        end
        if (need_w) d = (wk == wl) ? ((last_w > d) ? last_w : d) : 9998;
        if (need_r && d < 9998) d = (rk == rl) ? ((last_rv > d) ? last_rv : d) : 9998;
        done = d + 1;

        @(posedge calc_clk); #1;
        current_state = cmd;
        cfg_wr_base = 13'(wb); cfg_rd_base = 13'(rb);
        cfg_wr_len = 14'(wl);  cfg_rd_len = 14'(rl);
        drive_idle_inputs();
        for (int c = 0; c < T; c++) begin
            @(posedge calc_clk); #1;
            ddr_wr_valid = wv[c]; conv_wr_valid = wv[c];
            conv_rd_req = rq[c];  store_ready = rq[c];
            #3;
            ev = {wacc[c], (c > 0) && iss[c-1], c == done, c < done, (cmd == 3'd1) && (c < done)};
            av = {wr_en, rd_valid, state_rst, busy, fm_ddr_wr};
            chk($sformatf("strobes cmd%0d c%0d {wr_en,rd_valid,state_rst,busy,ddr}", cmd, c), 64'(av), 64'(ev));
            if (wacc[c]) chk($sformatf("wr_addr c%0d", c), 64'(wr_addr), 64'(waddr[c]));
            if (iss[c])  chk($sformatf("rd_addr c%0d", c), 64'(rd_addr), 64'(raddr[c]));
        end
        @(posedge calc_clk); #1;
        current_state = 3'd0;
        drive_idle_inputs();
        #3 chk("tail rd_valid drains", 64'(rd_valid), 64'(iss[T-1]));
        @(posedge calc_clk); #4;
        chk("tail idle {busy,state_rst,wr_en,rd_valid}",
            64'({busy, state_rst, wr_en, rd_valid}), 64'd0);
    endtask

    task automatic clear_stim();
        for (int c = 0; c < 64; c++) begin wv[c] = 0; rq[c] = 0; end
    endtask

    initial begin
        rst = 1'b1; current_state = 3'd0;
        cfg_wr_base = '0; cfg_rd_base = '0; cfg_wr_len = '0; cfg_rd_len = '0;
        drive_idle_inputs();
        #2 chk("reset outputs", 64'({wr_en, wr_addr, rd_addr, fm_ddr_wr, rd_valid, state_rst, busy}), 64'd0);
        @(negedge calc_clk); @(negedge calc_clk); rst = 1'b0;

        // LOAD across the address wrap, 6 valids against length 4
        clear_stim();
        for (int c = 0; c < 6; c++) wv[c] = 1;
        run_phase(3'd1, 'h1FFE, 0, 4, 0, 8);

        // STORE with ready 1,0,1,1
        clear_stim();
        rq[0] = 1; rq[2] = 1; rq[3] = 1;
        run_phase(3'd3, 0, 'h0123, 0, 3, 8);

        // CONV: reads finish first, one read+write overlap cycle
        clear_stim();
        for (int c = 0; c < 5; c++) rq[c] = 1;
        wv[2] = 1; wv[8] = 1;
        run_phase(3'd2, 'h0400, 'h0800, 2, 5, 12);

        // Zero-length LOAD
        clear_stim();
        for (int c = 0; c < 4; c++) wv[c] = 1;
        run_phase(3'd1, 'h0010, 0, 0, 0, 4);

        // Abort after 2 of 8 writes, then restart from the base
        clear_stim();
        wv[0] = 1; wv[1] = 1;
        run_phase(3'd1, 'h0100, 0, 8, 0, 2);
        clear_stim();
        wv[1] = 1; wv[2] = 1; wv[3] = 1;
        run_phase(3'd1, 'h0100, 0, 2, 0, 6);

        // Asynchronous reset mid-STORE, then illegal command 5
        @(posedge calc_clk); #1;
        current_state = 3'd3; cfg_rd_base = 13'h0050; cfg_rd_len = 14'd10; store_ready = 1;
        repeat (3) @(posedge calc_clk);
        #2 chk("pre-reset store activity {busy,rd_valid,rd_addr}",
               64'({busy, rd_valid, rd_addr}), 64'({1'b1, 1'b1, 13'h0052}));
        #1 rst = 1'b1;
        #1 chk("async reset outputs", 64'({wr_en, wr_addr, rd_addr, fm_ddr_wr, rd_valid, state_rst, busy}), 64'd0);
        current_state = 3'd0;
        @(negedge calc_clk); rst = 1'b0;
        current_state = 3'd5; ddr_wr_valid = 1; conv_wr_valid = 1; conv_rd_req = 1; store_ready = 1;
        cfg_wr_len = 14'd4;
        repeat (3) @(posedge calc_clk);
        #4 chk("cmd 5 stays idle {busy,wr_en,rd_valid,state_rst,ddr}",
               64'({busy, wr_en, rd_valid, state_rst, fm_ddr_wr}), 64'd0);
        current_state = 3'd0;
        drive_idle_inputs();

        // Randomized phases
        for (int it = 0; it < 10; it++) begin
            int cmd, wb, rb, wl, rl, dw, dr;
            cmd = $urandom_range(1, 3);
            wb = (it % 3 == 0) ? $urandom_range(8185, 8191) : $urandom_range(0, 8191);
            rb = (it % 3 == 1) ? $urandom_range(8185, 8191) : $urandom_range(0, 8191);
            wl = $urandom_range(0, 10);
            rl = $urandom_range(0, 10);
            dw = $urandom_range(1, 4);
            dr = $urandom_range(1, 4);
            for (int c = 0; c < 48; c++) begin
                wv[c] = (c >= 24) || ($urandom_range(0, 3) < dw);
                rq[c] = (c >= 24) || ($urandom_range(0, 3) < dr);
            end
            run_phase(3'(cmd), wb, rb, wl, rl, 48);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end
endmodule
